myproject_dot_accum: RTL

//  Downstream consumer of the signed x unsigned product multipliers in the MHA score/context datapath.

---
 rtl/myproject_dot_accum_if.sv | 33 +++
 rtl/myproject_dot_accum.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/myproject_dot_accum_if.sv
// ----------------------------------------------------------------------------
// myproject_dot_accum_if
//   Stream bundle for the dot-product accumulator: the signed product input
//   stream (prod_*), the rounded/saturated result stream (res_*) and the
//   length-error pulse.
//   Modports:
//     slave  - accumulator view: consumes prod_*, produces res_* and len_err
//     master - environment view: produces prod_*, consumes res_* and len_err
// ----------------------------------------------------------------------------
interface myproject_dot_accum_if #(
  parameter int unsigned IN_W  = 36,
  parameter int unsigned OUT_W = 16
);
  logic [IN_W-1:0]  prod_tdata;
  logic             prod_tvalid;
  logic             prod_tlast;
  logic             prod_tready;
  logic [OUT_W-1:0] res_tdata;
  logic             res_tvalid;
  logic             res_tready;
  logic             res_sat;
  logic             len_err;

  modport slave (
    input  prod_tdata, prod_tvalid, prod_tlast, res_tready,
    output prod_tready, res_tdata, res_tvalid, res_sat, len_err
  );

  modport master (
    output prod_tdata, prod_tvalid, prod_tlast, res_tready,
    input  prod_tready, res_tdata, res_tvalid, res_sat, len_err
  );
endinterface

// File: rtl/myproject_dot_accum.sv
// ----------------------------------------------------------------------------
// myproject_dot_accum
//   Sums NUM_TERMS signed IN_W-bit products into an ACC_W-bit accumulator,
//   then rounds (half toward +inf, SHIFT fractional bits dropped) and
//   saturates the total to a signed OUT_W-bit result held in a one-entry
//   registered valid/ready output. Groups are closed by beat count; prod_tlast
//   is only checked and reported through len_err.
//   Ports:
//     ap_clk    - clock, all state on rising edge
//     ap_rst_n  - asynchronous active-low reset
//     bus       - myproject_dot_accum_if.slave
//                   prod_tdata/tvalid/tlast in, prod_tready out
//                   res_tdata/tvalid/sat out, res_tready in
//                   len_err out (one-cycle pulse)
// ----------------------------------------------------------------------------
module myproject_dot_accum #(
  parameter int unsigned IN_W      = 36,
  parameter int unsigned ACC_W     = 42,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned SHIFT     = 10,
  parameter int unsigned NUM_TERMS = 64
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  myproject_dot_accum_if.slave   bus
);

  localparam int unsigned CNT_W    = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

  // Rounding constant 2^(SHIFT-1); zero when no bits are dropped.
  localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND =
    (SHIFT > 0) ? ((ACC_W+1)'(1) << RND_SH) : '0;

  // Output limits expressed in the widened rounding width.
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  // State
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    res_tvalid_q, res_tvalid_d;
  logic [OUT_W-1:0]        res_tdata_q, res_tdata_d;
  logic                    res_sat_q, res_sat_d;
  logic                    len_err_q, len_err_d;

  // Datapath / control
  logic                    at_last;
  logic                    accept;
  logic                    final_beat;
  logic                    drain;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W:0]   sum_ext;
  logic signed [ACC_W:0]   rounded;
  logic [OUT_W-1:0]        sat_data;
  logic                    sat_flag;

  // Handshake
  assign at_last         = (cnt_q == LAST_CNT);
  // Only a final beat can be blocked, and only while the previous result is
  // still held; non-final beats never touch the result register.
  assign bus.prod_tready = !(at_last && res_tvalid_q && !bus.res_tready);
  assign accept          = bus.prod_tvalid && bus.prod_tready;
  assign final_beat      = accept && at_last;
  assign drain           = res_tvalid_q && bus.res_tready;

  // Running sum including the current beat
  always_comb begin
    prod_ext = ACC_W'($signed(bus.prod_tdata));
    sum      = acc_q + prod_ext;
  end

  // Round in one extra bit so adding 2^(SHIFT-1) can never wrap.
  always_comb begin
    sum_ext = (ACC_W+1)'(sum);
    if (SHIFT > 0) begin
      rounded = (sum_ext + RND) >>> SHIFT;
    end else begin
      rounded = sum_ext;
    end
  end

  // Saturate to OUT_W signed
  always_comb begin
    sat_data = rounded[OUT_W-1:0];
    sat_flag = 1'b0;
    if (rounded > SAT_MAX) begin
      sat_data = SAT_MAX[OUT_W-1:0];
      sat_flag = 1'b1;
    end else if (rounded < SAT_MIN) begin
      sat_data = SAT_MIN[OUT_W-1:0];
      sat_flag = 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    res_tvalid_d = res_tvalid_q;
    res_tdata_d  = res_tdata_q;
    res_sat_d    = res_sat_q;

    if (accept) begin
      if (at_last) begin
        // Group closes; the next accepted beat starts a fresh sum.
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end

    // A final beat loading the register wins over a same-cycle drain.
    if (final_beat) begin
      res_tvalid_d = 1'b1;
      res_tdata_d  = sat_data;
      res_sat_d    = sat_flag;
    end else if (drain) begin
      res_tvalid_d = 1'b0;
    end

    // Covers both a tlast before the count ends and a missing tlast on it.
    len_err_d = accept && (bus.prod_tlast != at_last);
  end

  // State registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      res_tvalid_q <= 1'b0;
      res_tdata_q  <= '0;
      res_sat_q    <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      res_tvalid_q <= res_tvalid_d;
      res_tdata_q  <= res_tdata_d;
      res_sat_q    <= res_sat_d;
      len_err_q    <= len_err_d;
    end
  end

  assign bus.res_tdata  = res_tdata_q;
  assign bus.res_tvalid = res_tvalid_q;
  assign bus.res_sat    = res_sat_q;
  assign bus.len_err    = len_err_q;

endmodule
